pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 The block SHALL have parameter N_OUT, default 2, number of downstream reset channels (legal 1..8).
REQ-002 The block SHALL have parameter RST_CYCLES, default 16, length of each PLL reset pulse in clk cycles (legal >=1).
REQ-003 The block SHALL have parameter LOCK_TIMEOUT, default 65536, the number of cycles allowed in WAIT_LOCK before a retry (legal >=2).
REQ-004 The block SHALL have parameter LOCK_FILTER, default 256, the number of consecutive cycles lock_s must stay high before release (legal >=1).
REQ-005 The block SHALL have parameter STAGGER, default 16, the gap in cycles between successive channel releases (legal >=1).
REQ-006 The block SHALL have parameter MAX_RETRIES, default 3, the number of timeout retries allowed before FAULT (legal 0..15).
REQ-007 clk  input  1  single clock; the 25 MHz board clock, also the PLL reference; all logic is on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 locked  input  1  PLL LOCK output, asynchronous to clk.
REQ-010 pll_rst  output  1  drives PLL RST; active-high.
REQ-011 rst_out  output  N_OUT  per-domain reset requests; active-high; bit 0 is released first.
REQ-012 ready  output  1  high only in RUN.
REQ-013 fault  output  1  high only in FAULT.
REQ-014 relock_count  output  8  number of lock losses seen in RELEASE or RUN; saturates at 255.

Function
REQ-015 locked SHALL pass through a 2-flop synchroniser; lock_s denotes the second flop; every reference to lock below uses lock_s.
REQ-016 The FSM SHALL have the states PLLRST, WAIT_LOCK, FILTER, RELEASE, RUN and FAULT.
REQ-017 PLLRST: pll_rst=1 and rst_out all ones; after exactly RST_CYCLES cycles the FSM SHALL go to WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0 and a timeout counter runs.
- lock_s=1 -> FILTER.
- Counter reaches LOCK_TIMEOUT with lock_s=0, retries<MAX_RETRIES -> retries+1, then PLLRST.
- Counter reaches LOCK_TIMEOUT with lock_s=0, retries==MAX_RETRIES -> FAULT.
REQ-019 FILTER: a counter SHALL count consecutive lock_s=1 cycles.
- lock_s=0 -> WAIT_LOCK; the timeout counter restarts at 0.
- LOCK_FILTER consecutive high cycles -> RELEASE.
REQ-020 RELEASE: rst_out[0] SHALL clear on the first RELEASE cycle, and rst_out[k] SHALL clear exactly k*STAGGER cycles after rst_out[0]; released bits stay clear.
REQ-021 RELEASE -> RUN SHALL occur on the cycle after rst_out[N_OUT-1] clears; ready=1 from that cycle.
REQ-022 Lock loss in RELEASE or RUN (lock_s=0) SHALL cause all of the following in the next cycle: rst_out all ones, ready=0, relock_count+1 (saturating), retries cleared, and a transition to PLLRST.
REQ-023 FAULT SHALL be absorbing until reset: fault=1, pll_rst=0, rst_out all ones, ready=0; lock_s is ignored.
REQ-024 If lock_s falls on the same cycle a counter hits its terminal count, the loss of lock SHALL take priority.
REQ-025 Counters SHALL be sized as clog2(parameter)+1 bits, and no counter may wrap.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 While reset=1, the block SHALL hold: state=PLLRST, all counters=0, retries=0, relock_count=0, sync flops=0, pll_rst=1, rst_out all ones, ready=0, fault=0.
REQ-028 Reset asserted mid-operation (any state, including FAULT) SHALL take effect on the next edge, with the same values as REQ-027.
REQ-029 The PLLRST count SHALL start on the first edge with reset=0, so pll_rst stays high for RST_CYCLES cycles after reset deasserts.

Verification (N_OUT=3, RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_FILTER=8, STAGGER=4, MAX_RETRIES=2)
REQ-030 Nominal: release reset, raise locked 10 cycles later and hold it -> pll_rst high for 4 cycles; rst_out[0] clears 2+8 cycles after locked rises (±1 cycle); rst_out[1] clears 4 cycles later and rst_out[2] 8 cycles later; ready=1 one cycle after that.
REQ-031 Glitchy lock: pulse locked high for 5 cycles, low for 3, then hold it high -> no rst_out bit clears until 8 consecutive lock_s-high cycles.
REQ-032 Timeout/fault: hold locked=0 -> three pll_rst pulses of 4 cycles each, separated by 32-cycle waits; then fault=1 and it stays 1 even after locked rises; reset clears it.
REQ-033 Lock loss in RUN: drop locked for 1 cycle -> all rst_out high and ready=0 within 3 cycles; relock_count=1; a new 4-cycle pll_rst pulse; full staggered release repeats once lock_s is stable.
REQ-034 Saturation and mid-release reset: force 256 lock losses -> relock_count holds at 255; assert reset while in RELEASE with rst_out=3'b110 -> next cycle rst_out=3'b111, pll_rst=1 and relock_count=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a filtered lock, then
// releases downstream reset channels one at a time. A timed-out lock wait
// retries a bounded number of times before latching a fault. Losing lock after
// release restarts the whole sequence.
module pll_reset_sequencer #(
    parameter int unsigned N_OUT        = 2,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned LOCK_FILTER  = 256,
    parameter int unsigned STAGGER      = 16,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             locked,
    output logic             pll_rst,
    output logic [N_OUT-1:0] rst_out,
    output logic             ready,
    output logic             fault,
    output logic [7:0]       relock_count
);

    localparam int unsigned RstW = $clog2(RST_CYCLES) + 1;
    localparam int unsigned ToW  = $clog2(LOCK_TIMEOUT) + 1;
    localparam int unsigned FltW = $clog2(LOCK_FILTER) + 1;
    localparam int unsigned StgW = $clog2(STAGGER) + 1;

    // Terminal values: each phase lasts exactly its parameter in cycles
    localparam logic [RstW-1:0] RstLast  = RstW'(RST_CYCLES - 1);
    localparam logic [ToW-1:0]  ToLast   = ToW'(LOCK_TIMEOUT - 1);
    localparam logic [FltW-1:0] FltLast  = FltW'(LOCK_FILTER - 1);
    localparam logic [StgW-1:0] StgLast  = StgW'(STAGGER - 1);
    localparam logic [3:0]      RetryMax = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StPllRst,
        StWaitLock,
        StFilter,
        StRelease,
        StRun,
        StFault
    } state_t;

    state_t          state;
    logic            sync1;
    logic            lock_s;
    logic [RstW-1:0] rst_cnt;
    logic [ToW-1:0]  to_cnt;
    logic [FltW-1:0] flt_cnt;
    logic [StgW-1:0] stg_cnt;
    logic [3:0]      retries;

    // Two-flop synchroniser for the asynchronous PLL lock indication
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= locked;
            lock_s <= sync1;
        end
    end

    // Sequencer FSM with all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StPllRst;
            rst_cnt      <= '0;
            to_cnt       <= '0;
            flt_cnt      <= '0;
            stg_cnt      <= '0;
            retries      <= '0;
            relock_count <= '0;
            pll_rst      <= 1'b1;
            rst_out      <= '1;
            ready        <= 1'b0;
            fault        <= 1'b0;
        end else begin
            case (state)
                StPllRst: begin
                    pll_rst <= 1'b1;
                    rst_out <= '1;
                    ready   <= 1'b0;
                    if (rst_cnt == RstLast) begin
                        state   <= StWaitLock;
                        pll_rst <= 1'b0;
                        rst_cnt <= '0;
                        to_cnt  <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + RstW'(1);
                    end
                end

                StWaitLock: begin
                    if (lock_s) begin
                        state   <= StFilter;
                        flt_cnt <= '0;
                    end else if (to_cnt == ToLast) begin
                        to_cnt <= '0;
                        if (retries == RetryMax) begin
                            state <= StFault;
                            fault <= 1'b1;
                        end else begin
                            retries <= retries + 4'd1;
                            state   <= StPllRst;
                            pll_rst <= 1'b1;
                            rst_cnt <= '0;
                        end
                    end else begin
                        to_cnt <= to_cnt + ToW'(1);
                    end
                end

                StFilter: begin
                    // Any low sample discards the filter progress
                    if (!lock_s) begin
                        state  <= StWaitLock;
                        to_cnt <= '0;
                    end else if (flt_cnt == FltLast) begin
                        state   <= StRelease;
                        rst_out <= {N_OUT{1'b1}} << 1;
                        stg_cnt <= '0;
                    end else begin
                        flt_cnt <= flt_cnt + FltW'(1);
                    end
                end

                StRelease, StRun: begin
                    // Lock loss outranks any terminal count reached this cycle
                    if (!lock_s) begin
                        state   <= StPllRst;
                        rst_out <= '1;
                        ready   <= 1'b0;
                        pll_rst <= 1'b1;
                        rst_cnt <= '0;
                        retries <= '0;
                        if (relock_count != 8'hFF) begin
                            relock_count <= relock_count + 8'd1;
                        end
                    end else if (state == StRelease) begin
                        if (rst_out == '0) begin
                            state <= StRun;
                            ready <= 1'b1;
                        end else if (stg_cnt == StgLast) begin
                            // Released bits are contiguous from bit 0, so a
                            // left shift clears the next channel
                            rst_out <= rst_out << 1;
                            stg_cnt <= '0;
                        end else begin
                            stg_cnt <= stg_cnt + StgW'(1);
                        end
                    end
                end

                StFault: begin
                    fault   <= 1'b1;
                    pll_rst <= 1'b0;
                    rst_out <= '1;
                    ready   <= 1'b0;
                end

                default: begin
                    state   <= StPllRst;
                    pll_rst <= 1'b1;
                    rst_out <= '1;
                    ready   <= 1'b0;
                    fault   <= 1'b0;
                    rst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small parameters.
module tb_pll_reset_sequencer;

    localparam int unsigned N_OUT = 3;

    logic             clk;
    logic             reset;
    logic             locked;
    logic             pll_rst;
    logic [N_OUT-1:0] rst_out;
    logic             ready;
    logic             fault;
    logic [7:0]       relock_count;

    int n_checks = 0;
    int n_fail   = 0;

    pll_reset_sequencer #(
        .N_OUT       (N_OUT),
        .RST_CYCLES  (4),
        .LOCK_TIMEOUT(32),
        .LOCK_FILTER (8),
        .STAGGER     (4),
        .MAX_RETRIES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .locked      (locked),
        .pll_rst     (pll_rst),
        .rst_out     (rst_out),
        .ready       (ready),
        .fault       (fault),
        .relock_count(relock_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        locked = 1'b0;
        ticks(3);
        chk("reset_pll_rst", 32'(pll_rst), 1);
        chk("reset_rst_out", 32'(rst_out), 3'b111);
        chk("reset_ready", 32'(ready), 0);
        chk("reset_fault", 32'(fault), 0);
        chk("reset_relock", 32'(relock_count), 0);

        // Nominal bring-up
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("nom_pll_rst_hi", 32'(pll_rst), 1);
        end
        tick();
        chk("nom_pll_rst_lo", 32'(pll_rst), 0);
        locked = 1'b1;
        ticks(10);
        chk("nom_before_rel", 32'(rst_out), 3'b111);
        tick();
        chk("nom_rel0", 32'(rst_out), 3'b110);
        ticks(3);
        chk("nom_hold0", 32'(rst_out), 3'b110);
        tick();
        chk("nom_rel1", 32'(rst_out), 3'b100);
        ticks(3);
        chk("nom_hold1", 32'(rst_out), 3'b100);
        chk("nom_not_ready", 32'(ready), 0);
        tick();
        chk("nom_rel2", 32'(rst_out), 3'b000);
        chk("nom_ready_late", 32'(ready), 0);
        tick();
        chk("nom_ready", 32'(ready), 1);
        chk("nom_pll_rst_run", 32'(pll_rst), 0);

        // One-cycle lock drop while running
        locked = 1'b0;
        tick();
        chk("loss_ready_a", 32'(ready), 1);
        locked = 1'b1;
        tick();
        chk("loss_ready_b", 32'(ready), 1);
        tick();
        chk("loss_rst_out", 32'(rst_out), 3'b111);
        chk("loss_ready", 32'(ready), 0);
        chk("loss_pll_rst", 32'(pll_rst), 1);
        chk("loss_relock", 32'(relock_count), 1);
        ticks(3);
        chk("loss_pll_hold", 32'(pll_rst), 1);
        tick();
        chk("loss_pll_end", 32'(pll_rst), 0);
        ticks(8);
        chk("loss_before_rel", 32'(rst_out), 3'b111);
        tick();
        chk("loss_rel0", 32'(rst_out), 3'b110);
        ticks(4);
        chk("loss_rel1", 32'(rst_out), 3'b100);
        ticks(4);
        chk("loss_rel2", 32'(rst_out), 3'b000);
        tick();
        chk("loss_ready_again", 32'(ready), 1);

        // Reset from RUN, then a glitchy lock
        reset  = 1'b1;
        locked = 1'b0;
        tick();
        chk("midrst_pll_rst", 32'(pll_rst), 1);
        chk("midrst_rst_out", 32'(rst_out), 3'b111);
        chk("midrst_ready", 32'(ready), 0);
        chk("midrst_relock", 32'(relock_count), 0);
        reset = 1'b0;
        ticks(4);
        chk("glitch_pll_lo", 32'(pll_rst), 0);
        locked = 1'b1;
        ticks(5);
        locked = 1'b0;
        ticks(3);
        locked = 1'b1;
        for (int i = 13; i <= 22; i++) begin
            tick();
            chk("glitch_held", 32'(rst_out), 3'b111);
        end
        tick();
        chk("glitch_rel0", 32'(rst_out), 3'b110);

        // Timeout retries then fault, with lock held low
        reset  = 1'b1;
        locked = 1'b0;
        tick();
        reset = 1'b0;
        for (int t = 1; t <= 115; t++) begin
            logic exp_pll;
            logic exp_fault;
            tick();
            exp_pll   = (t < 4) || (t >= 36 && t < 40) || (t >= 72 && t < 76);
            exp_fault = (t >= 108);
            chk($sformatf("to_pll_rst_t%0d", t), 32'(pll_rst), 32'(exp_pll));
            chk($sformatf("to_fault_t%0d", t), 32'(fault), 32'(exp_fault));
        end
        locked = 1'b1;
        ticks(20);
        chk("fault_sticky", 32'(fault), 1);
        chk("fault_ready", 32'(ready), 0);
        chk("fault_rst_out", 32'(rst_out), 3'b111);
        chk("fault_pll_rst", 32'(pll_rst), 0);
        reset = 1'b1;
        tick();
        chk("fault_clr", 32'(fault), 0);
        chk("fault_clr_pll", 32'(pll_rst), 1);
        chk("fault_clr_rst_out", 32'(rst_out), 3'b111);
        reset = 1'b0;

        // Relock counter saturation
        for (int k = 1; k <= 256; k++) begin
            for (int i = 0; i < 100 && rst_out[0] !== 1'b0; i++) tick();
            chk($sformatf("sat_release_%0d", k), 32'(rst_out), 3'b110);
            locked = 1'b0;
            ticks(3);
            chk($sformatf("sat_loss_%0d", k), 32'(rst_out), 3'b111);
            chk($sformatf("sat_count_%0d", k), 32'(relock_count), (k > 255) ? 255 : k);
            locked = 1'b1;
        end

        // Reset in the middle of the staggered release
        for (int i = 0; i < 100 && rst_out[0] !== 1'b0; i++) tick();
        chk("mrel_state", 32'(rst_out), 3'b110);
        reset = 1'b1;
        tick();
        chk("mrel_rst_out", 32'(rst_out), 3'b111);
        chk("mrel_pll_rst", 32'(pll_rst), 1);
        chk("mrel_relock", 32'(relock_count), 0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
